// File: rtl/birds_up_ip.sv
// birds_up_ip -- read-only bird sprite memory for the Chrome-Dino renderer.
//
// Holds one 56x64 frame of 12-bit bbbb_gggg_rrrr pixels. The frame is
// chosen at elaboration time: FRAME=0 gives wings up, FRAME=1 gives wings
// down. Pixels come from fixed decode logic rather than an init file.
// The output is registered, so a read has one cycle of latency.
//
// Parameters:
//   FRAME  - 0 = wings up, 1 = wings down
//   HEIGHT - sprite rows (default 56)
//   LENGTH - sprite columns (default 64, must be a power of two)
//
// Ports:
//   clka  - clock; all state changes on the rising edge
//   rsta  - synchronous active-high reset; forces douta to 12'hFFF
//   addra - pixel address, row*LENGTH + col (full 16 bits decoded)
//   douta - registered pixel value
//
// Optional build macro:
//   BIRD_ROM_OUTREG_EN - adds a second output register, making the read
//                        latency 2 cycles. Reset clears both stages.
module birds_up_ip #(
  parameter int FRAME  = 0,
  parameter int HEIGHT = 56,
  parameter int LENGTH = 64
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic [15:0] addra,
  output logic [11:0] douta
);

  localparam int COL_BITS = $clog2(LENGTH);
  localparam int DEPTH    = HEIGHT * LENGTH;

  // The wing is the only region that moves between the two frames.
  localparam int WING_ROW_LO = (FRAME == 0) ? 8 : 36;
  localparam int WING_ROW_HI = WING_ROW_LO + 15;

  localparam logic [11:0] PIX_WHITE = 12'hFFF;
  localparam logic [11:0] PIX_EYE   = 12'h000;
  localparam logic [11:0] PIX_BEAK  = 12'h08F;
  localparam logic [11:0] PIX_GREY  = 12'h555;
  localparam logic [11:0] PIX_WING  = 12'h333;

  function automatic logic in_box(input int r, input int c,
                                  input int r_lo, input int r_hi,
                                  input int c_lo, input int c_hi);
    return (r >= r_lo) && (r <= r_hi) && (c >= c_lo) && (c <= c_hi);
  endfunction

  int          addr_i;
  int          row_i;
  int          col_i;
  logic [11:0] pixel_next;

  // Widen the address before any arithmetic so that out-of-range values
  // are rejected outright instead of aliasing back into the sprite.
  assign addr_i = int'({16'd0, addra});
  assign row_i  = addr_i >> COL_BITS;
  assign col_i  = addr_i & (LENGTH - 1);

  // Region tests are ordered highest priority first.
  always_comb begin
    pixel_next = PIX_WHITE;
    if (addr_i >= DEPTH) begin
      pixel_next = PIX_WHITE;
    end else if (in_box(row_i, col_i, 19, 20, 49, 50)) begin
      pixel_next = PIX_EYE;
    end else if (in_box(row_i, col_i, 20, 23, 56, 63)) begin
      pixel_next = PIX_BEAK;
    end else if (in_box(row_i, col_i, 16, 27, 44, 55)) begin
      pixel_next = PIX_GREY;
    end else if (in_box(row_i, col_i, 24, 35, 8, 51)) begin
      pixel_next = PIX_GREY;
    end else if (in_box(row_i, col_i, WING_ROW_LO, WING_ROW_HI, 20, 35)) begin
      pixel_next = PIX_WING;
    end
  end

  logic [11:0] dout_reg;

  always_ff @(posedge clka) begin
    if (rsta) begin
      dout_reg <= PIX_WHITE;
    end else begin
      dout_reg <= pixel_next;
    end
  end

`ifdef BIRD_ROM_OUTREG_EN
  logic [11:0] dout2_reg;

  always_ff @(posedge clka) begin
    if (rsta) begin
      dout2_reg <= PIX_WHITE;
    end else begin
      dout2_reg <= dout_reg;
    end
  end

  assign douta = dout2_reg;
`else
  assign douta = dout_reg;
`endif

endmodule

// File: tb/tb_birds_up_ip.sv
// Testbench for birds_up_ip. Both frames are instantiated side by side,
// the way the sprite renderer uses them, and share clock, reset and address.
module tb_birds_up_ip;

`ifdef BIRD_ROM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clka;
  logic        rsta;
  logic [15:0] addra;
  logic [11:0] douta0;
  logic [11:0] douta1;

  int checks;
  int failures;

  birds_up_ip #(.FRAME(0), .HEIGHT(56), .LENGTH(64)) u_up (
    .clka  (clka),
    .rsta  (rsta),
    .addra (addra),
    .douta (douta0)
  );

  birds_up_ip #(.FRAME(1), .HEIGHT(56), .LENGTH(64)) u_down (
    .clka  (clka),
    .rsta  (rsta),
    .addra (addra),
    .douta (douta1)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Reference sprite description: rectangles in priority order. A frame
  // value of -1 means the region appears in both frames.
  typedef struct {
    int          r0, r1, c0, c1;
    int          frame;
    logic [11:0] px;
  } region_t;

  region_t regions [6];

  function automatic logic [11:0] model(input int frame, input int a);
    int r;
    int c;
    if (a >= 56 * 64) return 12'hFFF;
    r = a / 64;
    c = a % 64;
    for (int i = 0; i < 6; i++) begin
      if ((regions[i].frame < 0 || regions[i].frame == frame) &&
          r >= regions[i].r0 && r <= regions[i].r1 &&
          c >= regions[i].c0 && c <= regions[i].c1)
        return regions[i].px;
    end
    return 12'hFFF;
  endfunction

  // Expected output pipelines, one per frame; the front entry is what
  // douta should show after the current edge.
  logic [11:0] exp0_q[$];
  logic [11:0] exp1_q[$];

  task automatic step(input string tag, input logic rst, input logic [15:0] a,
                      input logic [11:0] e0, input logic [11:0] e1);
    @(negedge clka);
    rsta  = rst;
    addra = a;
    @(posedge clka);
    #1;
    if (rst) begin
      for (int i = 0; i < exp0_q.size(); i++) begin
        exp0_q[i] = 12'hFFF;
        exp1_q[i] = 12'hFFF;
      end
      exp0_q.push_back(12'hFFF);
      exp1_q.push_back(12'hFFF);
    end else begin
      exp0_q.push_back(e0);
      exp1_q.push_back(e1);
    end
    while (exp0_q.size() > LAT) void'(exp0_q.pop_front());
    while (exp1_q.size() > LAT) void'(exp1_q.pop_front());
    checks++;
    assert (douta0 === exp0_q[0]) else begin
      failures++;
      $error("FAIL %s frame0 addr=%0d observed=%h expected=%h", tag, a, douta0, exp0_q[0]);
    end
    checks++;
    assert (douta1 === exp1_q[0]) else begin
      failures++;
      $error("FAIL %s frame1 addr=%0d observed=%h expected=%h", tag, a, douta1, exp1_q[0]);
    end
  endtask

  task automatic step_model(input string tag, input logic rst, input logic [15:0] a);
    step(tag, rst, a, model(0, int'(a)), model(1, int'(a)));
  endtask

  initial begin
    logic [15:0] ra;
    logic        rr;
    checks   = 0;
    failures = 0;
    rsta     = 1'b1;
    addra    = 16'd0;

    regions[0] = '{r0: 19, r1: 20, c0: 49, c1: 50, frame: -1, px: 12'h000};
    regions[1] = '{r0: 20, r1: 23, c0: 56, c1: 63, frame: -1, px: 12'h08F};
    regions[2] = '{r0: 16, r1: 27, c0: 44, c1: 55, frame: -1, px: 12'h555};
    regions[3] = '{r0: 24, r1: 35, c0: 8,  c1: 51, frame: -1, px: 12'h555};
    regions[4] = '{r0: 8,  r1: 23, c0: 20, c1: 35, frame: 0,  px: 12'h333};
    regions[5] = '{r0: 36, r1: 51, c0: 20, c1: 35, frame: 1,  px: 12'h333};

    for (int i = 0; i < LAT; i++) begin
      exp0_q.push_back(12'hFFF);
      exp1_q.push_back(12'hFFF);
    end

    // Reset held with a body address present, then released.
    step("reset0", 1'b1, 16'd1950, 12'hFFF, 12'hFFF);
    step("reset1", 1'b1, 16'd1950, 12'hFFF, 12'hFFF);
    step("release", 1'b0, 16'd1950, 12'h555, 12'h555);

    // Directed points with hand-derived expectations.
    step("body",      1'b0, 16'd1950,  12'h555, 12'h555);
    step("corner0",   1'b0, 16'd0,     12'hFFF, 12'hFFF);
    step("wing_up",   1'b0, 16'd665,   12'h333, 12'hFFF);
    step("wing_down", 1'b0, 16'd2585,  12'hFFF, 12'h333);
    step("eye",       1'b0, 16'd1265,  12'h000, 12'h000);
    step("beak",      1'b0, 16'd1404,  12'h08F, 12'h08F);
    step("last",      1'b0, 16'd3583,  12'hFFF, 12'hFFF);
    step("past_end",  1'b0, 16'd3584,  12'hFFF, 12'hFFF);
    step("max_addr",  1'b0, 16'hFFFF,  12'hFFF, 12'hFFF);
    step("body_back", 1'b0, 16'd1950,  12'h555, 12'h555);

    // Mid-stream reset discards the in-flight read.
    step("mid_rst", 1'b1, 16'd665, 12'hFFF, 12'hFFF);
    step("after_rst", 1'b0, 16'd1265, 12'h000, 12'h000);

    // Full address sweep against the reference model.
    for (int a = 0; a < 3584; a++) begin
      step_model("sweep", 1'b0, 16'(a));
    end

    // Random addresses across the whole 16-bit range, biased towards the
    // sprite, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) ra = 16'($urandom_range(0, 3599));
      else                           ra = 16'($urandom);
      rr = ($urandom_range(0, 31) == 0);
      step_model("random", rr, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
